uart_fifo_bridge: RTL

//  Byte-buffering stage between the bus/CSR side and the UART serial core.
//  TX path: CPU pushes bytes into a TX FIFO; a small FSM feeds the core one byte
//  at a time via tx_data/tx_wr and waits for tx_done. RX path: each core rx_done

---
 rtl/uart_fifo_pkg.sv | 11 +
 rtl/uart_fifo_bridge_if.sv | 36 +++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_fifo_bridge.sv | 91 +++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART byte-buffering bridge.
package uart_fifo_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// Bus/CSR and UART-core signals of the bridge; slave is the bridge view, master its peers.
interface uart_fifo_bridge_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    import uart_fifo_pkg::*;

    logic [DATA_W-1:0]   wr_data;
    logic                wr_en;
    logic                tx_full;
    logic [DEPTH_LOG2:0] tx_level;
    logic                tx_idle;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_en;
    logic                rx_empty;
    logic [DEPTH_LOG2:0] rx_level;
    logic                rx_overflow;
    logic                rx_ovf_clr;
    logic [DATA_W-1:0]   core_tx_data;
    logic                core_tx_wr;
    logic                core_tx_done;
    logic [DATA_W-1:0]   core_rx_data;
    logic                core_rx_done;

    modport slave (
        input  wr_data, wr_en, rd_en, rx_ovf_clr, core_tx_done, core_rx_data, core_rx_done,
        output tx_full, tx_level, tx_idle, rd_data, rx_empty, rx_level, rx_overflow,
               core_tx_data, core_tx_wr
    );

    modport master (
        output wr_data, wr_en, rd_en, rx_ovf_clr, core_tx_done, core_rx_data, core_rx_done,
        input  tx_full, tx_level, tx_idle, rd_data, rx_empty, rx_level, rx_overflow,
               core_tx_data, core_tx_wr
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module uart_sync_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATA_W-1:0]   push_data,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level,
    output logic [DATA_W-1:0]   head
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic                push_ok;
    logic                pop_ok;

    // Full/empty come from registered pointers, so a same-cycle pop never frees room.
    assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign level = wr_ptr_q - rd_ptr_q;
    assign head  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// TX/RX byte FIFOs between the CPU side and the UART core, with the TX feed FSM.
module uart_fifo_bridge
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    uart_fifo_bridge_if.slave  bus
);

    tx_state_e         state_q;
    logic [DATA_W-1:0] tx_head;
    logic [DATA_W-1:0] core_tx_data_q;
    logic              core_tx_wr_q;
    logic              tx_empty;
    logic              tx_pop;
    logic              rx_full;
    logic              rx_overflow_q;

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (tx_pop),
        .full      (bus.tx_full),
        .empty     (tx_empty),
        .level     (bus.tx_level),
        .head      (tx_head)
    );

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (bus.core_rx_done),
        .push_data (bus.core_rx_data),
        .pop       (bus.rd_en),
        .full      (rx_full),
        .empty     (bus.rx_empty),
        .level     (bus.rx_level),
        .head      (bus.rd_data)
    );

    assign tx_pop = (state_q == ST_IDLE) && !tx_empty;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= ST_IDLE;
            core_tx_wr_q   <= 1'b0;
            core_tx_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!tx_empty) begin
                        core_tx_data_q <= tx_head;
                        core_tx_wr_q   <= 1'b1;
                        state_q        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    core_tx_wr_q <= 1'b0;
                    if (bus.core_tx_done) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A dropped byte outranks a clear arriving in the same cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_overflow_q <= 1'b0;
        end else if (bus.core_rx_done && rx_full) begin
            rx_overflow_q <= 1'b1;
        end else if (bus.rx_ovf_clr) begin
            rx_overflow_q <= 1'b0;
        end
    end

    assign bus.core_tx_wr   = core_tx_wr_q;
    assign bus.core_tx_data = core_tx_data_q;
    assign bus.rx_overflow  = rx_overflow_q;
    assign bus.tx_idle      = (state_q == ST_IDLE) && tx_empty;

endmodule
